// File: rtl/sha_standard_pipelined_unpad_hash_pkg.sv
// Shared definitions for the padded-block unpadder and its sibling padder:
// hash state layout, padding constants and word positions inside a padded block.
package sha_standard_pipelined_unpad_hash_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } hash_state_t;

  localparam logic [31:0] SHA_PAD_LEN_256 = 32'd256;
  localparam logic [31:0] SHA_PAD_MARKER  = 32'h80000000;

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StHold    = 1'b1
  } unpad_state_t;

  // Word positions of the data fields within a padded block.
  localparam logic [3:0] IdxA    = 4'd0;
  localparam logic [3:0] IdxLen  = 4'd1;
  localparam logic [3:0] IdxPad  = 4'd8;
  localparam logic [3:0] IdxH    = 4'd9;
  localparam logic [3:0] IdxG    = 4'd10;
  localparam logic [3:0] IdxF    = 4'd11;
  localparam logic [3:0] IdxE    = 4'd12;
  localparam logic [3:0] IdxD    = 4'd13;
  localparam logic [3:0] IdxC    = 4'd14;
  localparam logic [3:0] IdxB    = 4'd15;

endpackage

// File: rtl/sha_standard_pipelined_unpad_hash_pad_word_check.sv
// Combinational check of one padded-block word against its fixed padding value.
// Data positions (0, 9..15) never report a mismatch.
module sha_standard_pipelined_unpad_hash_pad_word_check
  import sha_standard_pipelined_unpad_hash_pkg::*;
#(
  parameter logic [31:0] LenWord = SHA_PAD_LEN_256,
  parameter logic [31:0] PadWord = SHA_PAD_MARKER
) (
  input  logic [3:0]  idx_i,
  input  logic [31:0] word_i,
  output logic        mismatch_o
);

  always_comb begin
    mismatch_o = 1'b0;
    case (idx_i)
      IdxLen:                                   mismatch_o = (word_i != LenWord);
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:       mismatch_o = (word_i != 32'd0);
      IdxPad:                                   mismatch_o = (word_i != PadWord);
      default:                                  mismatch_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sha_standard_pipelined_unpad_hash.sv
// Collects a 16-word padded block one word per handshake, rebuilds the hash state
// and offers it downstream together with a sticky padding-error flag.
module sha_standard_pipelined_unpad_hash
  import sha_standard_pipelined_unpad_hash_pkg::*;
#(
  parameter logic [31:0] LEN_WORD = SHA_PAD_LEN_256,
  parameter logic [31:0] PAD_WORD = SHA_PAD_MARKER
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_start,
  input  logic [31:0] in_word,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output hash_state_t out_state,
  output logic        out_pad_error,
  output logic        drop_pulse
);

  unpad_state_t state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         err_q, err_d;
  logic         drop_q, drop_d;
  hash_state_t  hs_q, hs_d;
  logic         mismatch;

  sha_standard_pipelined_unpad_hash_pad_word_check #(
    .LenWord (LEN_WORD),
    .PadWord (PAD_WORD)
  ) u_pad_check (
    .idx_i      (idx_q),
    .word_i     (in_word),
    .mismatch_o (mismatch)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    hs_d    = hs_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (in_valid) begin
          if (in_start) begin
            // A start mid-block abandons whatever was collected so far.
            hs_d.a = in_word;
            idx_d  = 4'd1;
            err_d  = 1'b0;
            drop_d = (idx_q != IdxA);
          end else if (idx_q == IdxA) begin
            drop_d = 1'b1;
          end else begin
            err_d = err_q | mismatch;
            case (idx_q)
              IdxH:    hs_d.h = in_word;
              IdxG:    hs_d.g = in_word;
              IdxF:    hs_d.f = in_word;
              IdxE:    hs_d.e = in_word;
              IdxD:    hs_d.d = in_word;
              IdxC:    hs_d.c = in_word;
              IdxB:    hs_d.b = in_word;
              default: ;
            endcase
            idx_d = idx_q + 4'd1;
            if (idx_q == IdxB) begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StCollect;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      hs_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      hs_q    <= hs_d;
    end
  end

  assign in_ready      = (state_q == StCollect);
  assign out_valid     = (state_q == StHold);
  assign out_state     = hs_q;
  assign out_pad_error = err_q;
  assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_sha_standard_pipelined_unpad_hash.sv
// Bench for the padded-block unpadder: a word-level block model checked every cycle,
// plus directed literal checks for the documented scenarios.
module tb_sha_standard_pipelined_unpad_hash;
  import sha_standard_pipelined_unpad_hash_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_start = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  hash_state_t out_state;
  logic        out_pad_error;
  logic        drop_pulse;

  int checks = 0;
  int failures = 0;

  sha_standard_pipelined_unpad_hash dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_start      (in_start),
    .in_word       (in_word),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state     (out_state),
    .out_pad_error (out_pad_error),
    .drop_pulse    (drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Block model: raw words of the block in progress, decoded only when complete.
  logic [31:0] m_w [16];
  int          m_cnt;
  logic        m_hold;
  logic        m_drop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_hold <= 1'b0;
      m_drop <= 1'b0;
    end else begin
      m_drop <= 1'b0;
      if (m_hold) begin
        if (out_ready) m_hold <= 1'b0;
      end else if (in_valid) begin
        if (in_start) begin
          m_w[0] <= in_word;
          m_cnt  <= 1;
          m_drop <= (m_cnt != 0);
        end else if (m_cnt == 0) begin
          m_drop <= 1'b1;
        end else begin
          m_w[m_cnt] <= in_word;
          if (m_cnt == 15) begin
            m_cnt  <= 0;
            m_hold <= 1'b1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end
    end
  end

  function automatic logic model_err();
    logic e;
    e = (m_w[1] != 32'd256) || (m_w[8] != 32'h80000000);
    for (int i = 2; i <= 7; i++) e = e || (m_w[i] != 32'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
    check("drop_pulse", {31'd0, drop_pulse}, {31'd0, m_drop});
    if (m_hold) begin
      check("state_a", out_state.a, m_w[0]);
      check("state_h", out_state.h, m_w[9]);
      check("state_g", out_state.g, m_w[10]);
      check("state_f", out_state.f, m_w[11]);
      check("state_e", out_state.e, m_w[12]);
      check("state_d", out_state.d, m_w[13]);
      check("state_c", out_state.c, m_w[14]);
      check("state_b", out_state.b, m_w[15]);
      check("pad_error", {31'd0, out_pad_error}, {31'd0, model_err()});
    end
  end

  logic [31:0] blk [16];

  task automatic build_block(input logic [31:0] seed, input logic [31:0] pad8);
    blk[0] = 32'h11111111 ^ seed;
    blk[1] = 32'd256;
    for (int i = 2; i <= 7; i++) blk[i] = 32'd0;
    blk[8] = pad8;
    for (int i = 9; i <= 15; i++) blk[i] = (32'h11111111 * (17 - i)) ^ seed;
  endtask

  task automatic send_word(input logic s, input logic [31:0] w);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_start = s;
    in_word  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_word(i == 0, blk[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pad_error", {31'd0, out_pad_error}, 32'd0);
    check("rst_drop", {31'd0, drop_pulse}, 32'd0);
    check("rst_state_a", out_state.a, 32'd0);
    check("rst_state_b", out_state.b, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean block.
    build_block(32'd0, 32'h80000000);
    send_range(0, 15);
    check("clean_valid", {31'd0, out_valid}, 32'd1);
    check("clean_a", out_state.a, 32'h11111111);
    check("clean_h", out_state.h, 32'h88888888);
    check("clean_b", out_state.b, 32'h22222222);
    check("clean_err", {31'd0, out_pad_error}, 32'd0);
    @(negedge clk);
    check("clean_done", {31'd0, out_valid}, 32'd0);

    // Bad pad marker, then a clean block clears the flag.
    build_block(32'd0, 32'h00000080);
    send_range(0, 15);
    check("bad_valid", {31'd0, out_valid}, 32'd1);
    check("bad_err", {31'd0, out_pad_error}, 32'd1);
    check("bad_e", out_state.e, 32'h55555555);
    @(negedge clk);
    build_block(32'h0F0F0F0F, 32'h80000000);
    send_range(0, 15);
    check("after_bad_err", {31'd0, out_pad_error}, 32'd0);
    check("after_bad_a", out_state.a, 32'h1E1E1E1E);
    @(negedge clk);

    // Backpressure.
    out_ready = 1'b0;
    build_block(32'hA5A5A5A5, 32'h80000000);
    send_range(0, 15);
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_a", out_state.a, 32'hB4B4B4B4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {31'd0, in_ready}, 32'd1);

    // Mid-block restart at idx 6.
    build_block(32'h00FF00FF, 32'h80000000);
    send_range(0, 5);
    build_block(32'h12345678, 32'h80000000);
    send_range(0, 0);
    check("restart_drop", {31'd0, drop_pulse}, 32'd1);
    send_range(1, 15);
    check("restart_valid", {31'd0, out_valid}, 32'd1);
    check("restart_a", out_state.a, 32'h03254769);
    @(negedge clk);
    check("restart_single", {31'd0, out_valid}, 32'd0);

    // Stray word while idle.
    send_word(1'b0, 32'hDEADBEEF);
    check("stray_drop", {31'd0, drop_pulse}, 32'd1);
    @(negedge clk);
    check("stray_no_out", {31'd0, out_valid}, 32'd0);

    // Reset at idx 10.
    build_block(32'h0000FFFF, 32'h80000000);
    send_range(0, 9);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while holding a result.
    out_ready = 1'b0;
    build_block(32'h0000FFFF, 32'h80000000);
    send_range(0, 15);
    check("hold_before_rst", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;

    build_block(32'd0, 32'h80000000);
    send_range(0, 15);
    check("post_rst_a", out_state.a, 32'h11111111);
    check("post_rst_c", out_state.c, 32'h33333333);
    check("post_rst_err", {31'd0, out_pad_error}, 32'd0);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_standard_pipelined_unpad_hash.md
Name: sha_standard_pipelined_unpad_hash

Overview:
- Receive side of the wrapped second-pass padded block format.
- Accepts a 16-word padded block serially, one 32-bit word per handshake, and checks the fixed padding words.
- Reconstructs the HashState, then presents it with a valid/ready handshake plus a padding-error flag.
- Sits between the inter-core word link and the second-pass hash core input, or acts as a loopback checker for the padder.

Parameters:
- LEN_WORD, 32'd256, expected message-length word at index 1.
- PAD_WORD, 32'h80000000, expected pad-marker word at index 8.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_word is valid this cycle.
- in_start  in  1  qualifies in_word as word index 0 of a block.
- in_word  in  32  padded word.
- in_ready  out  1  block can accept a word.
- out_valid  out  1  out_state and out_pad_error are valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  HashState  reconstructed a..h.
- out_pad_error  out  1  any padding word mismatched in this block.
- drop_pulse  out  1  one-cycle pulse when a partial block or stray word is discarded.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=COLLECT, word counter idx=0, in_ready=1, out_valid=0, out_pad_error=0, drop_pulse=0, out_state all-zero.
- A word is accepted when in_valid && in_ready on a rising clk edge.
- Word layout by idx:
  - 0: a
  - 1: LEN_WORD
  - 2..7: 0
  - 8: PAD_WORD
  - 9: h
  - 10: g
  - 11: f
  - 12: e
  - 13: d
  - 14: c
  - 15: b
- Data words (0, 9..15) are registered into the matching HashState field.
- Padding words (1..8) are compared against their expected value; any mismatch sets a sticky err flag for the current block.
- State COLLECT:
  - in_ready=1.
  - Accept with in_start=1: load a, idx<=1, err<=0. If idx!=0 at that moment, pulse drop_pulse; the partial block is discarded.
  - Accept with in_start=0 and idx==0: word discarded, drop_pulse pulses, idx stays 0.
  - Accept with in_start=0 and idx in 1..14: process the word, then idx++.
  - Accept with in_start=0 and idx==15: load b, idx<=0, go to HOLD.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_state and out_pad_error are stable until out_ready=1.
  - On out_valid && out_ready: go to COLLECT next cycle, out_valid<=0.
- Latency: out_valid rises on the cycle after the word-15 accept.
- Minimum block period is 17 cycles: 16 accepts plus 1 handshake cycle. There is no overlap of HOLD and COLLECT.
- in_start while in HOLD: the word is not accepted because in_ready=0. No drop_pulse.
- reset_n low at any point, including mid-block or in HOLD: immediate return to the reset values. The partial block is lost without a drop_pulse.
- out_pad_error covers only words 1..8 of the delivered block. Data words are never checked.

Decomposition:
- Shared sha package holds:
  - HashState typedef (existing).
  - Constants SHA_PAD_LEN_256 = 32'd256 and SHA_PAD_MARKER = 32'h80000000, shared with the padder.
  - Enum unpad_state_t {COLLECT, HOLD}.
  - Index constants for a and h..b positions.
- A sub-module is natural: sha_pad_word_check. It is combinational: idx plus word in, mismatch out. It is reusable by the padder's assertion bench.

Test Plan:
- Clean block: a=32'h11111111, words 1..8 = 256,0,0,0,0,0,0,32'h80000000, h..b = 32'h88888888..32'h22222222, out_ready=1 → out_valid for one cycle, one cycle after word 15; a..h = 32'h11111111..32'h88888888; out_pad_error=0.
- Bad pad: same block but word 8 = 32'h00000080 → out_valid=1 with out_pad_error=1; state fields still correct. Following clean block → out_pad_error=0 (err cleared on in_start).
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_state held, in_ready=0 for all 5 cycles. out_ready=1 → in_ready=1 next cycle.
- Mid-block restart: in_start asserted at idx=6 → drop_pulse=1 for one cycle; the new block completes normally; exactly one out_valid is produced.
- Stray word: in_valid=1, in_start=0 at idx=0 → drop_pulse=1, idx stays 0, no output.
- Reset mid-operation: reset_n low at idx=10, and separately in HOLD → out_valid=0 and in_ready=1 immediately (asynchronous); a subsequent clean block decodes correctly.
